// File: rtl/rpm_scan_scheduler.sv
// rpm_scan_scheduler
// Shares one gated edge counter across up to eight encoder inputs. Each enabled
// channel is visited in round-robin order. Rising edges are counted over a fixed
// window, and the count is scaled to RPM. The result is then offered on a
// valid/ready stream, tagged with its channel index.

module rpm_scan_scheduler #(
  parameter int          NUM_CH        = 4,
  parameter logic [31:0] WINDOW_CYCLES = 32'd100000000,
  parameter logic [31:0] SCALE         = 32'd5
) (
  input  logic              i_clock,
  input  logic              i_reset,      // asynchronous, active low
  input  logic              i_enable,
  input  logic [NUM_CH-1:0] i_sa_input,
  input  logic [NUM_CH-1:0] i_ch_mask,
  output logic [31:0]       o_rpm_data,
  output logic [2:0]        o_rpm_ch,
  output logic              o_rpm_sat,
  output logic              o_rpm_valid,
  input  logic              i_rpm_ready,
  output logic              o_busy
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_WINDOW,
    ST_SCALE,
    ST_OUTPUT
  } state_t;

  localparam logic [3:0]  NUM_CH_W = 4'(NUM_CH);
  localparam logic [2:0]  LAST_CH  = 3'(NUM_CH - 1);
  localparam logic [31:0] LAST_WIN = WINDOW_CYCLES - 32'd1;
  localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

  // FSM state
  state_t r_state;
  state_t w_state_nxt;

  // Input conditioning: two synchronizer stages, a delayed copy, and the edge pulse
  logic [NUM_CH-1:0] r_sync_meta;
  logic [NUM_CH-1:0] r_sync_q;
  logic [NUM_CH-1:0] r_sync_qq;
  logic [NUM_CH-1:0] r_edge;

  // Scan bookkeeping
  logic [2:0]  r_ptr;
  logic [2:0]  r_cur_ch;
  logic [31:0] r_edge_cnt;
  logic [31:0] r_win_cnt;
  logic        r_sat_q;

  // Result stream registers
  logic [31:0] r_rpm_data;
  logic [2:0]  r_rpm_ch;
  logic        r_rpm_sat;
  logic        r_rpm_valid;

  // Combinational helpers
  logic        w_sel_found;
  logic [2:0]  w_sel_ch;
  logic [3:0]  w_best_dist;
  logic [3:0]  w_dist;
  logic        w_edge_sel;
  logic        w_win_last;
  logic [63:0] w_product;
  logic        w_prod_ovf;
  logic        w_handshake;
  logic [2:0]  w_ptr_nxt;

  // Synchronize every encoder input continuously and register its rising edge.
  // NOTE: sequential state uses non-blocking (<=) so that all flops update together
  // and chains like meta->q->qq shift by exactly one stage per clock.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_sync_meta <= '0;
      r_sync_q    <= '0;
      r_sync_qq   <= '0;
      r_edge      <= '0;
    end else begin
      r_sync_meta <= i_sa_input;
      r_sync_q    <= r_sync_meta;
      r_sync_qq   <= r_sync_q;
      r_edge      <= r_sync_q & ~r_sync_qq;
    end
  end

  // Find the first enabled channel at or after r_ptr, wrapping modulo NUM_CH.
  // The candidate with the smallest forward distance from r_ptr wins.
  // NOTE: every variable written here gets a value before any branch. This way
  // no path leaves one holding its old value, which would infer a latch.
  always_comb begin
    w_best_dist = NUM_CH_W;
    w_sel_ch    = '0;
    w_dist      = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (4'(i) >= {1'b0, r_ptr}) begin
        w_dist = 4'(i) - {1'b0, r_ptr};
      end else begin
        w_dist = 4'(i) + NUM_CH_W - {1'b0, r_ptr};
      end
      if (i_ch_mask[i] && (w_dist < w_best_dist)) begin
        w_best_dist = w_dist;
        w_sel_ch    = 3'(i);
      end
    end
  end

  assign w_sel_found = (w_best_dist != NUM_CH_W);

  // Route the edge pulse of the channel under measurement into the counter.
  always_comb begin
    w_edge_sel = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (3'(i) == r_cur_ch) begin
        w_edge_sel = r_edge[i];
      end
    end
  end

  assign w_win_last  = (r_win_cnt == LAST_WIN);
  assign w_product   = {32'd0, r_edge_cnt} * {32'd0, SCALE};
  assign w_prod_ovf  = |w_product[63:32];
  assign w_handshake = r_rpm_valid & i_rpm_ready;
  assign w_ptr_nxt   = (r_cur_ch == LAST_CH) ? 3'd0 : r_cur_ch + 3'd1;

  // FSM state register.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic. If enable drops during a window, the window is abandoned.
  // Once SCALE is reached, the result is always delivered before the FSM goes idle.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (i_enable) begin
          w_state_nxt = ST_SELECT;
        end
      end
      ST_SELECT: begin
        if (!i_enable) begin
          w_state_nxt = ST_IDLE;
        end else if (w_sel_found) begin
          w_state_nxt = ST_WINDOW;
        end
      end
      ST_WINDOW: begin
        if (!i_enable) begin
          w_state_nxt = ST_IDLE;
        end else if (w_win_last) begin
          w_state_nxt = ST_SCALE;
        end
      end
      ST_SCALE: begin
        w_state_nxt = ST_OUTPUT;
      end
      ST_OUTPUT: begin
        if (w_handshake) begin
          w_state_nxt = i_enable ? ST_SELECT : ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Window datapath: latch the chosen channel, then count its edges for the window.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_cur_ch   <= '0;
      r_edge_cnt <= '0;
      r_win_cnt  <= '0;
      r_sat_q    <= 1'b0;
    end else begin
      case (r_state)
        ST_SELECT: begin
          if (i_enable && w_sel_found) begin
            r_cur_ch   <= w_sel_ch;
            r_edge_cnt <= '0;
            r_win_cnt  <= '0;
            r_sat_q    <= 1'b0;
          end
        end
        ST_WINDOW: begin
          r_win_cnt <= r_win_cnt + 32'd1;
          if (w_edge_sel) begin
            if (r_edge_cnt == ALL_ONES) begin
              r_sat_q <= 1'b1;
            end else begin
              r_edge_cnt <= r_edge_cnt + 32'd1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Result register: load the scaled value in SCALE, and hold it until a handshake.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_rpm_data  <= '0;
      r_rpm_ch    <= '0;
      r_rpm_sat   <= 1'b0;
      r_rpm_valid <= 1'b0;
    end else if (r_state == ST_SCALE) begin
      r_rpm_data  <= w_prod_ovf ? ALL_ONES : w_product[31:0];
      r_rpm_sat   <= w_prod_ovf | r_sat_q;
      r_rpm_ch    <= r_cur_ch;
      r_rpm_valid <= 1'b1;
    end else if ((r_state == ST_OUTPUT) && w_handshake) begin
      r_rpm_valid <= 1'b0;
    end
  end

  // Move the round-robin pointer past a channel only after its result is accepted.
  // As a result, an aborted window re-measures the same channel.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_ptr <= '0;
    end else if ((r_state == ST_OUTPUT) && w_handshake) begin
      r_ptr <= w_ptr_nxt;
    end
  end

  assign o_rpm_data  = r_rpm_data;
  assign o_rpm_ch    = r_rpm_ch;
  assign o_rpm_sat   = r_rpm_sat;
  assign o_rpm_valid = r_rpm_valid;
  assign o_busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_rpm_scan_scheduler.sv
// Testbench for rpm_scan_scheduler.
// Encoder pulses are issued in bursts placed well inside each expected window.
// For each expected result, a scoreboard records (channel, edge count x SCALE,
// saturation). The record comes from the number of pulses issued to that
// channel during that window. A negedge compare process checks every accepted
// result against the scoreboard. While valid is stalled, it also checks that
// the result holds steady.

module tb_rpm_scan_scheduler;

  localparam int          NUM_CH = 4;
  localparam logic [31:0] WIN    = 32'd100;
  localparam logic [31:0] SCL    = 32'd5;
  localparam logic [31:0] SCL_HI = 32'hFFFF_FFFF;
  localparam int          PERIOD = 103;   // window start spacing with ready held high

  logic              clk = 1'b0;
  logic              rst_n;
  logic              en;
  logic              en2;
  logic [NUM_CH-1:0] sa;
  logic [NUM_CH-1:0] mask;
  logic              ready;

  logic [31:0] data;
  logic [2:0]  ch;
  logic        sat;
  logic        valid;
  logic        busy;

  logic [31:0] data2;
  logic [2:0]  ch2;
  logic        sat2;
  logic        valid2;
  logic        busy2;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  typedef struct packed {
    logic [2:0]  ch;
    logic        sat;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  rpm_scan_scheduler #(
    .NUM_CH       (NUM_CH),
    .WINDOW_CYCLES(WIN),
    .SCALE        (SCL)
  ) u_dut (
    .i_clock    (clk),
    .i_reset    (rst_n),
    .i_enable   (en),
    .i_sa_input (sa),
    .i_ch_mask  (mask),
    .o_rpm_data (data),
    .o_rpm_ch   (ch),
    .o_rpm_sat  (sat),
    .o_rpm_valid(valid),
    .i_rpm_ready(ready),
    .o_busy     (busy)
  );

  rpm_scan_scheduler #(
    .NUM_CH       (NUM_CH),
    .WINDOW_CYCLES(WIN),
    .SCALE        (SCL_HI)
  ) u_dut_sat (
    .i_clock    (clk),
    .i_reset    (rst_n),
    .i_enable   (en2),
    .i_sa_input (sa),
    .i_ch_mask  (mask),
    .o_rpm_data (data2),
    .o_rpm_ch   (ch2),
    .o_rpm_sat  (sat2),
    .o_rpm_valid(valid2),
    .i_rpm_ready(ready),
    .o_busy     (busy2)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=0x%0h expected=0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected result for a window that saw 'edges' rising edges.
  function automatic exp_t model(input logic [2:0] c, input int edges, input logic [31:0] scale);
    exp_t        e;
    logic [63:0] p;
    p      = 64'(edges) * 64'(scale);
    e.ch   = c;
    if (p > 64'hFFFF_FFFF) begin
      e.data = 32'hFFFF_FFFF;
      e.sat  = 1'b1;
    end else begin
      e.data = p[31:0];
      e.sat  = 1'b0;
    end
    return e;
  endfunction

  // Compare process for the main DUT.
  logic        p_valid = 1'b0;
  logic        p_ready = 1'b0;
  logic [31:0] p_data  = '0;
  logic [2:0]  p_ch    = '0;
  logic        p_sat   = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      p_valid <= 1'b0;
    end else begin
      if (p_valid && !p_ready) begin
        check("hold_stable", {valid, ch, sat, data}, {1'b1, p_ch, p_sat, p_data});
      end
      if (valid && ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 64'(valid), 64'd0);
        end else begin
          check("result", {ch, sat, data}, {exp_q[0].ch, exp_q[0].sat, exp_q[0].data});
          void'(exp_q.pop_front());
        end
      end
      p_valid <= valid;
      p_ready <= ready;
      p_data  <= data;
      p_ch    <= ch;
      p_sat   <= sat;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) tick();
  endtask

  // One pulse slot is 2 cycles high and 3 low. Channel k pulses in the first ck slots.
  task automatic burst(input int c0, input int c1, input int c2, input int c3);
    int mx;
    mx = c0;
    if (c1 > mx) mx = c1;
    if (c2 > mx) mx = c2;
    if (c3 > mx) mx = c3;
    for (int p = 0; p < mx; p++) begin
      sa = {(p < c3), (p < c2), (p < c1), (p < c0)};
      tick();
      tick();
      sa = '0;
      repeat (3) tick();
    end
  endtask

  task automatic do_reset();
    en    = 1'b0;
    en2   = 1'b0;
    sa    = '0;
    mask  = '0;
    ready = 1'b1;
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic wait_drain(input string name, input int max);
    int n;
    n = 0;
    while ((exp_q.size() != 0) && (n < max)) begin
      tick();
      n++;
    end
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic stop_run(input string name);
    int n;
    en = 1'b0;
    n  = 0;
    while (busy && (n < 10)) begin
      tick();
      n++;
    end
    check(name, 64'(busy), 64'd0);
  endtask

  task automatic wait_valid(input string name, input int max);
    int n;
    n = 0;
    while (!valid && (n < max)) begin
      tick();
      n++;
    end
    check(name, 64'(valid), 64'd1);
  endtask

  task automatic wait_valid2(input string name, input int max);
    int n;
    n = 0;
    while (!valid2 && (n < max)) begin
      tick();
      n++;
    end
    check(name, 64'(valid2), 64'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int   t0;
    int   t1;
    int   r;
    logic seen;

    // Reset state, observed before any clock edge
    rst_n = 1'b0;
    en    = 1'b0;
    en2   = 1'b0;
    sa    = '0;
    mask  = '0;
    ready = 1'b1;
    #2;
    check("reset_data",  64'(data),  64'd0);
    check("reset_ch",    64'(ch),    64'd0);
    check("reset_sat",   64'(sat),   64'd0);
    check("reset_valid", 64'(valid), 64'd0);
    check("reset_busy",  64'(busy),  64'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Scenario 1: ch0 alone, 10 pulses -> 50. SELECT is entered on the first edge
    // after enable, and valid follows 102 cycles later, i.e. at t0+103.
    mask = 4'b0001;
    t0   = cyc;
    en   = 1'b1;
    exp_q.push_back(model(3'd0, 10, SCL));
    wait_until(t0 + 12);
    burst(10, 0, 0, 0);
    wait_valid("s1_valid", 200);
    check("s1_latency", 64'(cyc - t0), 64'd103);
    check("s1_data_lit", 64'(data), 64'd50);
    check("s1_ch_lit",   64'(ch),   64'd0);
    check("s1_sat_lit",  64'(sat),  64'd0);
    wait_drain("s1_drain", 50);
    stop_run("s1_idle");

    // Scenario 2: mask 1011, 1/2/3/4 pulses per window -> ch0, ch1, ch3, ch0
    do_reset();
    mask = 4'b1011;
    t0   = cyc;
    en   = 1'b1;
    exp_q.push_back(model(3'd0, 1, SCL));
    exp_q.push_back(model(3'd1, 2, SCL));
    exp_q.push_back(model(3'd3, 4, SCL));
    exp_q.push_back(model(3'd0, 1, SCL));
    for (int k = 0; k < 4; k++) begin
      wait_until(t0 + 2 + PERIOD * k + 10);
      burst(1, 2, 3, 4);
    end
    wait_drain("s2_drain", 400);
    stop_run("s2_idle");

    // Scenario 3: ready held low for 50 cycles. Pulses issued during the stall must
    // not be counted, and the next window starts right after ready rises.
    do_reset();
    mask  = 4'b0001;
    ready = 1'b0;
    t0    = cyc;
    en    = 1'b1;
    exp_q.push_back(model(3'd0, 3, SCL));
    wait_until(t0 + 12);
    burst(3, 0, 0, 0);
    wait_valid("s3_valid", 200);
    repeat (10) tick();
    burst(4, 0, 0, 0);
    repeat (20) tick();
    check("s3_busy_stall", 64'(busy), 64'd1);
    exp_q.push_back(model(3'd0, 2, SCL));
    r     = cyc;
    ready = 1'b1;
    tick();
    check("s3_valid_drop", 64'(valid), 64'd0);
    wait_until(r + 15);
    burst(2, 0, 0, 0);
    wait_valid("s3_valid2", 200);
    check("s3_restart_latency", 64'(cyc - r), 64'd103);
    wait_drain("s3_drain", 50);
    stop_run("s3_idle");

    // Scenario 4: ch1 completes. Enable then drops at cycle 40 of the ch2 window.
    // After re-enable, ch2 is measured again (15), not ch1 (10).
    do_reset();
    mask = 4'b0110;
    t0   = cyc;
    en   = 1'b1;
    exp_q.push_back(model(3'd1, 2, SCL));
    wait_until(t0 + 12);
    burst(0, 2, 3, 0);
    wait_until(t0 + 2 + PERIOD + 10);
    burst(0, 2, 3, 0);
    wait_until(t0 + 2 + PERIOD + 39);
    en = 1'b0;
    tick();
    check("s4_busy_abort", 64'(busy), 64'd0);
    seen = 1'b0;
    repeat (120) begin
      tick();
      seen = seen | valid;
    end
    check("s4_no_result", 64'(seen), 64'd0);
    t1 = cyc;
    en = 1'b1;
    exp_q.push_back(model(3'd2, 3, SCL));
    wait_until(t1 + 12);
    burst(0, 2, 3, 0);
    wait_drain("s4_drain", 200);
    stop_run("s4_idle");

    // Scenario 5: empty mask keeps the FSM in SELECT. Mask 0100 then yields ch2.
    // Next, reset is asserted between clock edges in the middle of a window.
    do_reset();
    mask = 4'b0000;
    en   = 1'b1;
    seen = 1'b0;
    repeat (30) begin
      tick();
      seen = seen | valid;
    end
    check("s5_busy_nomask", 64'(busy), 64'd1);
    check("s5_no_output", 64'(seen), 64'd0);
    t0   = cyc;
    mask = 4'b0100;
    exp_q.push_back(model(3'd2, 1, SCL));
    wait_until(t0 + 12);
    burst(0, 0, 1, 0);
    wait_drain("s5_drain", 200);
    wait_until(t0 + 150);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("s5_async_data",  64'(data),  64'd0);
    check("s5_async_ch",    64'(ch),    64'd0);
    check("s5_async_sat",   64'(sat),   64'd0);
    check("s5_async_valid", 64'(valid), 64'd0);
    check("s5_async_busy",  64'(busy),  64'd0);
    en = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Scenario 6: SCALE = 0xFFFFFFFF. One edge gives exactly 0xFFFFFFFF, which is
    // not saturated. Two edges overflow, giving 0xFFFFFFFF with the saturated flag set.
    do_reset();
    mask = 4'b0001;
    t0   = cyc;
    en2  = 1'b1;
    wait_until(t0 + 12);
    burst(1, 0, 0, 0);
    wait_valid2("s6_valid1", 200);
    check("s6_data1_lit", 64'(data2), 64'hFFFF_FFFF);
    check("s6_sat1_lit",  64'(sat2),  64'd0);
    check("s6_ch1_lit",   64'(ch2),   64'd0);
    wait_until(t0 + 2 + PERIOD + 10);
    burst(2, 0, 0, 0);
    wait_valid2("s6_valid2", 200);
    check("s6_data2_lit", 64'(data2), 64'hFFFF_FFFF);
    check("s6_sat2_lit",  64'(sat2),  64'd1);
    en2 = 1'b0;
    repeat (4) tick();
    check("s6_idle", 64'(busy2), 64'd0);

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rpm_scan_scheduler.md
# rpm_scan_scheduler

Time-multiplexes one gated edge-counting datapath across up to eight motor encoder sense inputs. It visits each enabled channel in round-robin order, counts rising edges over a fixed window, scales the count to RPM, and emits one tagged result per window on a valid/ready stream. It sits between the encoder pins and the motor-control and register layer, and replaces per-channel free-running RPM counters.

## Interface
Parameters:
- NUM_CH, 4: number of encoder channels, 2..8.
- WINDOW_CYCLES, 32'd100000000: measurement window length in clock cycles, ≥2 (1 s at 100 MHz).
- SCALE, 32'd5: multiplier applied to the edge count to produce RPM.

Ports:
- clock  in  1  system clock; all logic is on its rising edge.
- reset  in  1  asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- enable  in  1  run request; low stops scheduling.
- sa_input  in  NUM_CH  raw encoder inputs, asynchronous to clock.
- ch_mask  in  NUM_CH  per-channel enable; bit i=1 means channel i is scanned.
- rpm_data  out  32  scaled result.
- rpm_ch  out  3  channel index of rpm_data.
- rpm_sat  out  1  result saturated; qualifies rpm_data.
- rpm_valid  out  1  result available.
- rpm_ready  in  1  consumer accepts the result.
- busy  out  1  high whenever the state is not IDLE.

## Operation
- Each sa_input bit passes through a 2-flop synchronizer, then a rising-edge detector (sync_q & ~sync_qq). All channels are synchronized continuously.
- FSM states: IDLE, SELECT, WINDOW, SCALE, OUTPUT.
- IDLE: go to SELECT when enable=1.
- SELECT (1 cycle):
  - Sample ch_mask.
  - Pick the first set bit at or after ptr, wrapping modulo NUM_CH.
  - If no bit is set, stay in SELECT. If enable=0, go to IDLE.
  - Otherwise load cur_ch, clear edge_cnt and win_cnt, and go to WINDOW.
- WINDOW (exactly WINDOW_CYCLES cycles):
  - edge_cnt increments on each cycle where the edge pulse of cur_ch is high.
  - edge_cnt is a 32-bit saturating counter; on saturation it holds 0xFFFFFFFF and sets sat_q.
  - win_cnt counts 0..WINDOW_CYCLES-1. At the last value, go to SCALE.
- SCALE (1 cycle):
  - Compute product = edge_cnt × SCALE in 64 bits.
  - If the product exceeds 0xFFFFFFFF, rpm_data = 0xFFFFFFFF and rpm_sat = 1. Otherwise rpm_data = product[31:0] and rpm_sat = sat_q.
  - Set rpm_ch = cur_ch and rpm_valid = 1. Go to OUTPUT.
- OUTPUT:
  - rpm_data, rpm_ch and rpm_sat are held stable while rpm_valid=1.
  - On rpm_valid & rpm_ready: clear rpm_valid and set ptr = cur_ch+1 (wrapping).
  - Then go to SELECT if enable=1, otherwise IDLE.
- enable falling in WINDOW: abort on the next edge, discard the count, go to IDLE. No result is produced and ptr is unchanged.
- enable falling in SCALE or OUTPUT: the result completes and is delivered before going to IDLE. rpm_valid never drops without a handshake.
- ch_mask changes take effect only at SELECT. A channel masked mid-window still completes its window.
- Single enabled channel: that channel is measured back-to-back.

## Timing
- Reset values:
  - rpm_data=0, rpm_ch=0, rpm_sat=0, rpm_valid=0, busy=0.
  - ptr=0, state=IDLE, synchronizers=0.
- Pin-to-count latency: 3 cycles (2 synchronizer stages plus the edge register). An edge is counted if its pulse falls inside the window cycles.
- Cycles from entering SELECT to rpm_valid high: 1 + WINDOW_CYCLES + 1.
- With rpm_ready held high, rpm_valid is high for 1 cycle. The next window starts WINDOW_CYCLES + 3 cycles after the previous one started.
- Pulses narrower than 1 clock or faster than clock/2 are not guaranteed to be counted.
- Reset asserted mid-operation: all state returns to reset values immediately, without waiting for a clock edge.

## Test plan
Bench settings for all scenarios: WINDOW_CYCLES=100, SCALE=5, NUM_CH=4.
- ch_mask=4'b0001, enable=1, 10 pulses (2 high / 3 low cycles) on ch0 inside the window -> rpm_valid with rpm_ch=0, rpm_data=50, rpm_sat=0, first valid 102 cycles after SELECT.
- ch_mask=4'b1011, rpm_ready=1, pulses of 1/2/3/4 per window on ch0..3 -> results in order ch0=5, ch1=10, ch3=20, ch0=5; ch2 is never reported.
- rpm_ready=0 for 50 cycles after valid -> rpm_data and rpm_ch stay stable and no new window starts; a window starts 1 cycle after ready rises.
- enable dropped at cycle 40 of a window -> no rpm_valid and busy=0 next cycle. Re-enable -> the same channel is remeasured.
- ch_mask=0 with enable=1 -> busy=1 and no output. Setting ch_mask=4'b0100 -> the next result has rpm_ch=2.
- SCALE=32'hFFFFFFFF with 2 edges -> rpm_data=32'hFFFFFFFF, rpm_sat=1. Reset pulsed mid-window -> all outputs 0 immediately.
